// File: rtl/accum_cpu_core.sv
// 8-bit single-accumulator CPU with a 256x8 unified program/data memory.
// Fixed 2-byte instructions run in a FETCH/OPERAND/EXECUTE loop; HLT parks the core until reset.
module accum_cpu_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [7:0] accumulator_out,
  output logic [7:0] program_counter_out
);

  typedef enum logic [1:0] {StFetch, StOperand, StExecute, StHalt} state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opr_q, opr_d;
  logic       mem_we;
  logic [7:0] pc_inc;
  logic [7:0] mem_opr;

  // Not reset: preloaded contents must survive a reset.
  logic [7:0] memory [256];

  assign pc_inc  = pc_q + 8'd1;
  assign mem_opr = memory[opr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      acc_q   <= 8'h00;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

  // Write enable is only raised in EXECUTE, so an async reset mid-instruction drops the store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      memory[opr_q] <= acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_d    = memory[pc_q];
        state_d = StOperand;
      end
      StOperand: begin
        opr_d   = memory[pc_inc];
        state_d = StExecute;
      end
      StExecute: begin
        pc_d    = pc_q + 8'd2;
        state_d = StFetch;
        case (ir_q)
          8'h01: acc_d = mem_opr;
          8'h02: acc_d = acc_q - mem_opr;
          8'h03: acc_d = acc_q + mem_opr;
          8'h04: mem_we = 1'b1;
          8'h05: acc_d = opr_q;
          8'h06: acc_d = data_in;
          8'h07: pc_d = opr_q;
          8'h08: if (acc_q == 8'h00) pc_d = opr_q;
          8'h09: acc_d = acc_q & mem_opr;
          8'h0A: acc_d = acc_q | mem_opr;
          8'h0B: acc_d = acc_q ^ mem_opr;
          8'hFF: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  assign accumulator_out     = acc_q;
  assign program_counter_out = pc_q;

endmodule

// File: tb/tb_accum_cpu_core.sv
// Scoreboard bench for accum_cpu_core: per-instruction acc/pc expectations are queued,
// then popped and compared after each 3-edge instruction.
module tb_accum_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] acc;
  logic [7:0] pc;

  accum_cpu_core dut (
    .clk                 (clk),
    .reset               (reset),
    .data_in             (data_in),
    .accumulator_out     (acc),
    .program_counter_out (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [7:0] a, input logic [7:0] p);
    exp_t e;
    e.tag = tag;
    e.acc = a;
    e.pc  = p;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      tick(3);
      e = sb.pop_front();
      check_eq({e.tag, ".acc"}, acc, e.acc);
      check_eq({e.tag, ".pc"}, pc, e.pc);
    end
  endtask

  task automatic put(input int addr, input logic [7:0] b);
    dut.memory[addr] = b;
  endtask

  task automatic enter_reset_clear();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.memory[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    enter_reset_clear();
    #1;
    check_eq("rst.acc", acc, 8'h00);
    check_eq("rst.pc", pc, 8'h00);

    // LDI 00; ADD 0A; STA 14
    put(0, 8'h05); put(1, 8'h00); put(2, 8'h03); put(3, 8'h0A);
    put(4, 8'h04); put(5, 8'h14); put(6, 8'h00); put(10, 8'h07);
    release_reset();
    expect_instr("t1.ldi", 8'h00, 8'h02);
    expect_instr("t1.add", 8'h07, 8'h04);
    expect_instr("t1.sta", 8'h07, 8'h06);
    drain();
    check_eq("t1.mem20", dut.memory[20], 8'h07);

    // Overflow, then JMP FE and NOP across the pc wrap
    enter_reset_clear();
    put(0, 8'h05); put(1, 8'hF0); put(2, 8'h03); put(3, 8'h20);
    put(4, 8'h07); put(5, 8'hFE); put(8'h20, 8'h20);
    release_reset();
    expect_instr("t2.ldi", 8'hF0, 8'h02);
    expect_instr("t2.add", 8'h10, 8'h04);
    expect_instr("t2.jmp", 8'h10, 8'hFE);
    expect_instr("t2.wrap", 8'h10, 8'h00);
    drain();

    // JZ taken / not taken, JMP, IN, HLT
    enter_reset_clear();
    put(0, 8'h05);    put(1, 8'h00);    put(2, 8'h08);    put(3, 8'h40);
    put(8'h40, 8'h05); put(8'h41, 8'h01); put(8'h42, 8'h08); put(8'h43, 8'h40);
    put(8'h44, 8'h07); put(8'h45, 8'h80);
    put(8'h80, 8'h06); put(8'h81, 8'h00); put(8'h82, 8'h07); put(8'h83, 8'h10);
    put(8'h10, 8'hFF); put(8'h11, 8'h00);
    data_in = 8'hA5;
    release_reset();
    expect_instr("t3.ldi0", 8'h00, 8'h02);
    expect_instr("t3.jz_t", 8'h00, 8'h40);
    expect_instr("t3.ldi1", 8'h01, 8'h42);
    expect_instr("t3.jz_n", 8'h01, 8'h44);
    expect_instr("t3.jmp", 8'h01, 8'h80);
    expect_instr("t4.in", 8'hA5, 8'h82);
    expect_instr("t4.jmp", 8'hA5, 8'h10);
    expect_instr("t4.hlt", 8'hA5, 8'h10);
    drain();
    data_in = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_eq("t4.hold.acc", acc, 8'hA5);
      check_eq("t4.hold.pc", pc, 8'h10);
    end

    // Reset during OPERAND of STA 30 must drop the store
    enter_reset_clear();
    put(0, 8'h05); put(1, 8'h3C); put(2, 8'h04); put(3, 8'h30); put(8'h30, 8'h99);
    release_reset();
    expect_instr("t5.ldi", 8'h3C, 8'h02);
    drain();
    tick(1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5.rst.acc", acc, 8'h00);
    check_eq("t5.rst.pc", pc, 8'h00);
    tick(3);
    check_eq("t5.mem30", dut.memory[8'h30], 8'h99);
    check_eq("t5.mem0", dut.memory[0], 8'h05);
    check_eq("t5.mem1", dut.memory[1], 8'h3C);
    check_eq("t5.mem2", dut.memory[2], 8'h04);
    check_eq("t5.mem3", dut.memory[3], 8'h30);

    // Unknown opcodes and the logic/sub ops
    enter_reset_clear();
    put(0, 8'h05);  put(1, 8'h0F);  put(2, 8'h55);  put(3, 8'h77);
    put(4, 8'h02);  put(5, 8'h30);  put(6, 8'h09);  put(7, 8'h31);
    put(8, 8'h0A);  put(9, 8'h32);  put(10, 8'h0B); put(11, 8'h33);
    put(12, 8'h01); put(13, 8'h30); put(14, 8'h0C); put(15, 8'h00);
    put(16, 8'hFF); put(17, 8'h00);
    put(8'h30, 8'h99); put(8'h31, 8'h3C); put(8'h32, 8'h81); put(8'h33, 8'hFF);
    release_reset();
    expect_instr("t6.ldi", 8'h0F, 8'h02);
    expect_instr("t6.op55", 8'h0F, 8'h04);
    expect_instr("t6.sub", 8'h76, 8'h06);
    expect_instr("t6.and", 8'h34, 8'h08);
    expect_instr("t6.or", 8'hB5, 8'h0A);
    expect_instr("t6.xor", 8'h4A, 8'h0C);
    expect_instr("t6.lda", 8'h99, 8'h0E);
    expect_instr("t6.op0c", 8'h99, 8'h10);
    expect_instr("t6.hlt", 8'h99, 8'h10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
